// File: rtl/prim_count_bank.sv
// prim_count_bank: a bank of independent hardened counters. Each channel keeps a
// primary up-counter and a complementary down-counter, each with its own adder.
// The two must always sum to all-ones. A channel whose pair stops summing to
// all-ones raises a sticky integrity error, and any such error drives the alert.
module prim_count_bank #(
  parameter int              Width       = 8,
  parameter int              NumChannels = 4,
  parameter int              Wrap        = 0,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumChannels-1:0]       clr_i,
  input  logic [NumChannels-1:0]       set_i,
  input  logic [NumChannels*Width-1:0] set_cnt_i,
  input  logic [NumChannels-1:0]       incr_en_i,
  input  logic [NumChannels-1:0]       decr_en_i,
  input  logic [NumChannels*Width-1:0] step_i,
  input  logic [NumChannels-1:0]       commit_i,
  input  logic [NumChannels*Width-1:0] thresh_i,
  output logic [NumChannels*Width-1:0] cnt_o,
  output logic [NumChannels*Width-1:0] cnt_after_commit_o,
  output logic [NumChannels-1:0]       hit_o,
  output logic [NumChannels-1:0]       ovf_o,
  output logic [NumChannels-1:0]       err_o,
  output logic                         alert_o
);

  localparam logic [Width-1:0] AllOnes = '1;

  // Resolve a Width+1 bit adder result: on carry/borrow either clamp to the
  // bound in the direction of travel or keep the low bits (modulo wrap).
  function automatic logic [Width-1:0] sat_wrap(input logic [Width:0] sum,
                                                input logic       clamp_high);
    logic [Width-1:0] res;
    res = sum[Width-1:0];
    if (sum[Width] && (Wrap == 0)) begin
      res = clamp_high ? AllOnes : '0;
    end
    return res;
  endfunction

  for (genvar k = 0; k < NumChannels; k++) begin : g_ch
    logic [Width-1:0] up_q, dn_q, up_d, dn_d;
    logic [Width-1:0] step, set_val, thr;
    logic [Width:0]   up_sum, dn_sum;
    logic             cnt_op, ovf_d, mismatch;
    logic             hit_q, ovf_q, err_q;

    assign step    = step_i[k*Width +: Width];
    assign set_val = set_cnt_i[k*Width +: Width];
    assign thr     = thresh_i[k*Width +: Width];
    assign cnt_op  = incr_en_i[k] ^ decr_en_i[k];

    // Two separate adders so a fault in one path cannot silently track the other.
    assign up_sum = incr_en_i[k] ? ({1'b0, up_q} + {1'b0, step})
                                 : ({1'b0, up_q} - {1'b0, step});
    assign dn_sum = incr_en_i[k] ? ({1'b0, dn_q} - {1'b0, step})
                                 : ({1'b0, dn_q} + {1'b0, step});

    // Candidate next values: clear beats set beats count beats hold.
    always_comb begin
      up_d  = up_q;
      dn_d  = dn_q;
      ovf_d = 1'b0;
      if (clr_i[k]) begin
        up_d = ResetValue;
        dn_d = ~ResetValue;
      end else if (set_i[k]) begin
        up_d = set_val;
        dn_d = AllOnes - set_val;
      end else if (cnt_op) begin
        ovf_d = up_sum[Width];
        up_d  = sat_wrap(up_sum, incr_en_i[k]);
        dn_d  = sat_wrap(dn_sum, decr_en_i[k]);
      end
    end

    assign mismatch = ({1'b0, up_q} + {1'b0, dn_q}) != {1'b0, AllOnes};

    // Counter pair: only a commit moves the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        up_q <= ResetValue;
        dn_q <= ~ResetValue;
      end else if (commit_i[k]) begin
        up_q <= up_d;
        dn_q <= dn_d;
      end
    end

    // Event pulses and the sticky integrity flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        hit_q <= 1'b0;
        ovf_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        hit_q <= commit_i[k] && (up_d == thr) && (up_q != thr);
        ovf_q <= commit_i[k] && ovf_d;
        err_q <= err_q | mismatch;
      end
    end

    assign cnt_o[k*Width +: Width]              = up_q;
    assign cnt_after_commit_o[k*Width +: Width] = up_d;
    assign hit_o[k] = hit_q;
    assign ovf_o[k] = ovf_q;
    assign err_o[k] = mismatch | err_q;
  end

  assign alert_o = |err_o;

endmodule

// File: tb/tb_prim_count_bank.sv
// Testbench for prim_count_bank: a saturating and a wrapping instance share the
// same stimulus and are compared every cycle against an integer-arithmetic model.
module tb_prim_count_bank;

  localparam int         W    = 8;
  localparam int         NC   = 4;
  localparam int         MAXV = (1 << W) - 1;
  localparam logic [W-1:0] RV = 8'h00;

  logic clk, rst;
  logic [NC-1:0]   clr, set, incr, decr, commit;
  logic [NC*W-1:0] set_cnt, step, thresh;

  logic [NC*W-1:0] cnt_s, cac_s, cnt_w, cac_w;
  logic [NC-1:0]   hit_s, ovf_s, err_s, hit_w, ovf_w, err_w;
  logic            alert_s, alert_w;

  prim_count_bank #(.Width(W), .NumChannels(NC), .Wrap(0), .ResetValue(RV)) dut_s (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .set_i(set), .set_cnt_i(set_cnt),
    .incr_en_i(incr), .decr_en_i(decr), .step_i(step), .commit_i(commit),
    .thresh_i(thresh), .cnt_o(cnt_s), .cnt_after_commit_o(cac_s), .hit_o(hit_s),
    .ovf_o(ovf_s), .err_o(err_s), .alert_o(alert_s));

  prim_count_bank #(.Width(W), .NumChannels(NC), .Wrap(1), .ResetValue(RV)) dut_w (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .set_i(set), .set_cnt_i(set_cnt),
    .incr_en_i(incr), .decr_en_i(decr), .step_i(step), .commit_i(commit),
    .thresh_i(thresh), .cnt_o(cnt_w), .cnt_after_commit_o(cac_w), .hit_o(hit_w),
    .ovf_o(ovf_w), .err_o(err_w), .alert_o(alert_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_up_s [NC];
  logic [W-1:0] m_up_w [NC];
  logic [W:0]   nx_s [NC];
  logic [W:0]   nx_w [NC];
  logic [NC-1:0] m_hit_s, m_ovf_s, m_hit_w, m_ovf_w;
  logic m_err0, force_on;

  logic [NC*W-1:0] exp_cnt_s, exp_cac_s, exp_cnt_w, exp_cac_w;
  logic [NC-1:0]   exp_err_s;

  // Returns {event, next value} from plain integer arithmetic.
  function automatic logic [W:0] nxt(input logic [W-1:0] up, input int ch, input bit wrap);
    int v;
    int stp;
    bit ev;
    logic [W-1:0] r;
    v   = int'(up);
    stp = int'(step[ch*W +: W]);
    ev  = 1'b0;
    r   = up;
    if (clr[ch]) r = RV;
    else if (set[ch]) r = set_cnt[ch*W +: W];
    else if (incr[ch] != decr[ch]) begin
      v = incr[ch] ? v + stp : v - stp;
      if (v > MAXV || v < 0) begin
        ev = 1'b1;
        if (wrap) v = (v + MAXV + 1) % (MAXV + 1);
        else      v = (v < 0) ? 0 : MAXV;
      end
      r = v[W-1:0];
    end
    return {ev, r};
  endfunction

  always_comb begin
    exp_cnt_s = '0;
    exp_cac_s = '0;
    exp_cnt_w = '0;
    exp_cac_w = '0;
    exp_err_s = '0;
    for (int ch = 0; ch < NC; ch++) begin
      nx_s[ch] = nxt(m_up_s[ch], ch, 1'b0);
      nx_w[ch] = nxt(m_up_w[ch], ch, 1'b1);
      exp_cnt_s[ch*W +: W] = m_up_s[ch];
      exp_cnt_w[ch*W +: W] = m_up_w[ch];
      exp_cac_s[ch*W +: W] = nx_s[ch][W-1:0];
      exp_cac_w[ch*W +: W] = nx_w[ch][W-1:0];
    end
    exp_err_s[0] = m_err0 | force_on;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < NC; ch++) begin
        m_up_s[ch] <= RV;
        m_up_w[ch] <= RV;
      end
      m_hit_s <= '0; m_ovf_s <= '0; m_hit_w <= '0; m_ovf_w <= '0;
      m_err0  <= 1'b0;
    end else begin
      if (force_on) m_err0 <= 1'b1;
      for (int ch = 0; ch < NC; ch++) begin
        if (commit[ch]) begin
          m_up_s[ch]  <= nx_s[ch][W-1:0];
          m_up_w[ch]  <= nx_w[ch][W-1:0];
          m_hit_s[ch] <= (nx_s[ch][W-1:0] == thresh[ch*W +: W]) && (m_up_s[ch] != thresh[ch*W +: W]);
          m_hit_w[ch] <= (nx_w[ch][W-1:0] == thresh[ch*W +: W]) && (m_up_w[ch] != thresh[ch*W +: W]);
          m_ovf_s[ch] <= nx_s[ch][W];
          m_ovf_w[ch] <= nx_w[ch][W];
        end else begin
          m_hit_s[ch] <= 1'b0; m_hit_w[ch] <= 1'b0;
          m_ovf_s[ch] <= 1'b0; m_ovf_w[ch] <= 1'b0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic compare_all();
    chk("cnt_s",   64'(cnt_s),   64'(exp_cnt_s));
    chk("cac_s",   64'(cac_s),   64'(exp_cac_s));
    chk("hit_s",   64'(hit_s),   64'(m_hit_s));
    chk("ovf_s",   64'(ovf_s),   64'(m_ovf_s));
    chk("err_s",   64'(err_s),   64'(exp_err_s));
    chk("alert_s", 64'(alert_s), 64'(|exp_err_s));
    chk("cnt_w",   64'(cnt_w),   64'(exp_cnt_w));
    chk("cac_w",   64'(cac_w),   64'(exp_cac_w));
    chk("hit_w",   64'(hit_w),   64'(m_hit_w));
    chk("ovf_w",   64'(ovf_w),   64'(m_ovf_w));
    chk("err_w",   64'(err_w),   64'(0));
    chk("alert_w", 64'(alert_w), 64'(0));
  endtask

  // Compare at the falling edge, then advance to just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = '0; set = '0; incr = '0; decr = '0; commit = '0;
  endtask

  task automatic drive(input int ch, input bit c, input bit s, input logic [W-1:0] sv,
                       input bit inc, input bit dec, input logic [W-1:0] st, input bit cm);
    clr[ch] = c; set[ch] = s; set_cnt[ch*W +: W] = sv;
    incr[ch] = inc; decr[ch] = dec; step[ch*W +: W] = st; commit[ch] = cm;
  endtask

  task automatic rand_inputs();
    for (int ch = 0; ch < NC; ch++) begin
      clr[ch]    = ($urandom_range(0, 15) == 0);
      set[ch]    = ($urandom_range(0, 7) == 0);
      incr[ch]   = 1'($urandom_range(0, 1));
      decr[ch]   = 1'($urandom_range(0, 1));
      commit[ch] = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: step[ch*W +: W] = '0;
        1: step[ch*W +: W] = W'(1);
        2: step[ch*W +: W] = W'($urandom_range(0, 7));
        default: step[ch*W +: W] = W'($urandom_range(0, MAXV));
      endcase
      case ($urandom_range(0, 4))
        0: set_cnt[ch*W +: W] = '0;
        1: set_cnt[ch*W +: W] = W'(MAXV);
        2: set_cnt[ch*W +: W] = W'(MAXV - 1);
        3: set_cnt[ch*W +: W] = W'(1);
        default: set_cnt[ch*W +: W] = W'($urandom_range(0, MAXV));
      endcase
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 2))
          0: thresh[ch*W +: W] = W'(2);
          1: thresh[ch*W +: W] = W'(MAXV);
          default: thresh[ch*W +: W] = W'($urandom_range(0, MAXV));
        endcase
      end
    end
  endtask

  initial begin
    force_on = 1'b0;
    rst = 1'b1;
    idle();
    set_cnt = '0; step = '0; thresh = '0;
    cyc(); cyc();
    chk("rst_cnt_s", 64'(cnt_s), 64'(0));
    chk("rst_flags", 64'({hit_s, ovf_s, err_s, alert_s}), 64'(0));
    rst = 1'b0;

    // Channel 0 counts up by one for five commits.
    drive(0, 0, 0, '0, 1, 0, 8'd1, 1);
    repeat (5) cyc();
    idle();
    chk("t1_cnt0", 64'(cnt_s[7:0]), 64'(5));
    chk("t1_dn0", 64'(dut_s.g_ch[0].dn_q), 64'(250));
    chk("t1_others", 64'(cnt_s[31:8]), 64'(0));

    // Channel 1 saturation at the top and bottom.
    drive(1, 0, 1, 8'hFE, 0, 0, 8'd0, 1); cyc();
    drive(1, 0, 0, 8'h00, 1, 0, 8'd4, 1); cyc();
    chk("t2_sat_hi", 64'(cnt_s[15:8]), 64'(8'hFF));
    chk("t2_ovf_hi", 64'(ovf_s[1]), 64'(1));
    idle(); cyc();
    chk("t2_ovf_once", 64'(ovf_s[1]), 64'(0));
    drive(1, 0, 1, 8'h05, 0, 0, 8'd0, 1); cyc();
    drive(1, 0, 0, 8'h00, 0, 1, 8'h10, 1); cyc();
    chk("t2_sat_lo", 64'(cnt_s[15:8]), 64'(0));
    chk("t2_ovf_lo", 64'(ovf_s[1]), 64'(1));
    idle();

    // Channel 2 wraps in the modulo instance, then holds with both enables.
    drive(2, 0, 1, 8'hFE, 0, 0, 8'd0, 1); cyc();
    drive(2, 0, 0, 8'h00, 1, 0, 8'd4, 1); cyc();
    chk("t3_wrap", 64'(cnt_w[23:16]), 64'(8'h02));
    chk("t3_ovf", 64'(ovf_w[2]), 64'(1));
    drive(2, 0, 0, 8'h00, 1, 1, 8'd4, 1); cyc(); cyc();
    chk("t3_hold", 64'(cnt_w[23:16]), 64'(8'h02));
    idle();

    // Channel 3 threshold hit fires once; uncommitted candidate is visible.
    thresh[31:24] = 8'h10;
    drive(3, 0, 1, 8'h0E, 0, 0, 8'd0, 1); cyc();
    drive(3, 0, 0, 8'h00, 1, 0, 8'd1, 1); cyc();
    chk("t4_nohit", 64'(hit_s[3]), 64'(0));
    cyc();
    chk("t4_hit", 64'(hit_s[3]), 64'(1));
    cyc();
    chk("t4_hit_once", 64'(hit_s[3]), 64'(0));
    chk("t4_cnt", 64'(cnt_s[31:24]), 64'(8'h11));
    commit[3] = 1'b0;
    #1;
    chk("t4_cac", 64'(cac_s[31:24]), 64'(8'h12));
    cyc();
    chk("t4_nocommit", 64'(cnt_s[31:24]), 64'(8'h11));
    idle();

    // Randomized traffic on all channels.
    repeat (400) begin
      rand_inputs();
      cyc();
    end

    // Integrity fault on channel 0 of the saturating instance.
    idle();
    drive(0, 1, 0, '0, 0, 0, '0, 1); cyc();
    idle();
    force dut_s.g_ch[0].dn_q = '0;
    force_on = 1'b1;
    #1;
    chk("t5_err", 64'(err_s[0]), 64'(1));
    chk("t5_alert", 64'(alert_s), 64'(1));
    cyc();
    release dut_s.g_ch[0].dn_q;
    force_on = 1'b0;
    cyc(); cyc();
    chk("t5_sticky", 64'(err_s[0]), 64'(1));
    chk("t5_other", 64'(err_s[3:1]), 64'(0));
    repeat (60) begin
      rand_inputs();
      cyc();
    end

    // Reset in the middle of activity with clear and set asserted.
    rand_inputs();
    clr = '1; set = '1; commit = '1;
    cyc();
    rst = 1'b1;
    #1;
    chk("t6_cnt_s", 64'(cnt_s), 64'(0));
    chk("t6_cnt_w", 64'(cnt_w), 64'(0));
    chk("t6_flags", 64'({hit_s, ovf_s, err_s, alert_s, hit_w, ovf_w, err_w}), 64'(0));
    cyc(); cyc();
    idle();
    rst = 1'b0;
    cyc();
    chk("t6_release", 64'({hit_s, ovf_s, err_s, hit_w, ovf_w, err_w}), 64'(0));
    repeat (100) begin
      rand_inputs();
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
